nios_core_pll_rst_seq: RTL and testbench
========================================

NIOS_CORE_PLL_RST_SEQ -- requirements
Module: nios_core_pll_rst_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width in refclk cycles (range 1..65535).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 50000: maximum refclk cycles to wait for lock per attempt (range 2..2^20-1).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before releasing the system reset (range 1..65535).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3: lock timeouts tolerated before entering FAULT (range 1..15).
REQ-005 refclk  input  1  free-running reference clock, the only clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 sw_relock  input  1  synchronous single-cycle request to restart the PLL sequence.
REQ-009 pll_rst  output  1  active-high reset driven to the PLL.
REQ-010 sys_reset_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 pll_ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 retry_cnt  output  4  lock timeouts counted in the current sequence.

Function
REQ-014 pll_locked SHALL pass through a two-flop synchronizer; "locked" below means the synchronizer output.
REQ-015 The FSM SHALL have states RST_PLL, WAIT_LOCK, STABLE, RUN and FAULT, and all outputs SHALL be registered from the state and counters.
REQ-016 RST_PLL: pll_rst=1 and sys_reset_n=0 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked=1 SHALL go to STABLE; LOCK_TIMEOUT cycles without lock SHALL increment retry_cnt and go to RST_PLL, or to FAULT if the incremented value equals MAX_RETRY.
REQ-018 STABLE: STABLE_CYCLES consecutive locked cycles SHALL go to RUN; any locked=0 SHALL return to WAIT_LOCK with the timeout counter restarted and retry_cnt unchanged.
REQ-019 RUN: sys_reset_n=1 and pll_ready=1; locked=0 SHALL go to RST_PLL, with sys_reset_n=0 and pll_ready=0 on the next edge and retry_cnt cleared.
REQ-020 FAULT: pll_rst=1, sys_reset_n=0, fault=1 and retry_cnt held; leave only on sw_relock or rst_n.
REQ-021 sw_relock=1 in any state SHALL go to RST_PLL with retry_cnt=0 and the RST_CYCLES count restarted; it SHALL have priority over every simultaneous timeout or lock event.
REQ-022 Minimum latency from pll_locked rising to sys_reset_n rising SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles.
REQ-023 sys_reset_n SHALL never be 1 while pll_rst is 1.

Reset
REQ-024 On rst_n=0 the block SHALL asynchronously set state=RST_PLL, pll_rst=1, sys_reset_n=0, pll_ready=0, fault=0, retry_cnt=0, clear all counters and synchronizer flops.
REQ-025 On rst_n deassertion the RST_PLL count SHALL start at the first refclk edge; assertion mid-operation SHALL abort any state immediately.

Configuration
REQ-026 With macro PLL_SEQ_LOCKLOSS_CNT_EN defined, the block SHALL add output lockloss_cnt (8 bits, reset 0): it increments on each RUN-to-RST_PLL transition caused by lock loss, saturates at 255, is not cleared by sw_relock, and is cleared only by rst_n.
REQ-027 Without PLL_SEQ_LOCKLOSS_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-028 Release rst_n with pll_locked tied 1 -> pll_rst=1 for 4 cycles, then sys_reset_n=1 and pll_ready=1 exactly 2+8+1 cycles after WAIT_LOCK entry.
REQ-029 Hold pll_locked=0 -> two 100-cycle timeouts, retry_cnt goes 1 then 2, fault=1, pll_rst=1; pulse sw_relock -> retry_cnt=0, fault=0 and a new RST_PLL phase.
REQ-030 Glitch pll_locked low for 3 cycles at STABLE count 5 -> return to WAIT_LOCK, no retry increment, RUN reached 8 locked cycles after recovery.
REQ-031 Drop pll_locked in RUN -> sys_reset_n=0 and pll_ready=0 within 3 cycles, then pll_rst=1 for 4 cycles; lockloss_cnt=1 when the macro is defined.
REQ-032 Assert sw_relock in the same cycle as the WAIT_LOCK timeout expiry -> RST_PLL with retry_cnt=0, never FAULT.
REQ-033 Assert rst_n=0 during STABLE -> all outputs at reset values asynchronously, with no refclk edge required.

Source files
------------

// File: rtl/nios_core_pll_rst_seq.sv
// PLL reset / lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_reset_n.
// Optional PLL_SEQ_LOCKLOSS_CNT_EN adds a saturating lock-loss counter output.
module nios_core_pll_rst_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_relock,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  ,
  output logic [7:0] lockloss_cnt
`endif
);

  localparam logic [2:0] RST_PLL   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    sync_q, sync_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          pll_ready_q, pll_ready_d;
  logic          fault_q, fault_d;
  logic          locked;
  logic [3:0]    retry_inc;

`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  logic [7:0]    lockloss_q, lockloss_d;
  logic          lockloss_inc;
`endif

  assign locked    = sync_q[1];
  assign retry_inc = retry_q + 4'd1;

  // Lock is meaningless while the PLL is held in reset, so the
  // synchronizer is flushed there and must re-qualify afterwards.
  always_comb begin
    sync_d = {sync_q[0], pll_locked};
    if (state_q == RST_PLL || state_q == FAULT) begin
      sync_d = 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    lockloss_inc = 1'b0;
`endif
    if (sw_relock) begin
      state_d = RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RST_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? FAULT : RST_PLL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!locked) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == ST_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
            lockloss_inc = 1'b1;
`endif
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RST_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    pll_rst_d     = (state_d == RST_PLL) || (state_d == FAULT);
    sys_reset_n_d = (state_d == RUN);
    pll_ready_d   = (state_d == RUN);
    fault_d       = (state_d == FAULT);
  end

`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  always_comb begin
    lockloss_d = lockloss_q;
    if (lockloss_inc && lockloss_q != 8'hFF) begin
      lockloss_d = lockloss_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      sync_q        <= 2'b00;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      pll_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      sync_q        <= sync_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      pll_ready_q   <= pll_ready_d;
      fault_q       <= fault_d;
    end
  end

`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lockloss_q <= 8'd0;
    end else begin
      lockloss_q <= lockloss_d;
    end
  end

  assign lockloss_cnt = lockloss_q;
`endif

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign pll_ready   = pll_ready_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_nios_core_pll_rst_seq.sv
// Directed bench for nios_core_pll_rst_seq with
// RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2.
module tb_nios_core_pll_rst_seq;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_relock;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_cnt;
`endif

  int checks;
  int errors;

  nios_core_pll_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .sw_relock  (sw_relock),
    .pll_rst    (pll_rst),
    .sys_reset_n(sys_reset_n),
    .pll_ready  (pll_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    ,
    .lockloss_cnt(lockloss_cnt)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pll_locked = 1'b1; sw_relock = 1'b0;
    #23;
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b exp 1", pll_rst); end
    checks++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL reset_sys_reset_n: got %b exp 0", sys_reset_n); end
    checks++; if (pll_ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_ready_fault: got %b%b exp 00", pll_ready, fault); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d exp 0", retry_cnt); end
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    checks++; if (lockloss_cnt !== 8'd0) begin errors++; $display("FAIL reset_lockloss: got %0d exp 0", lockloss_cnt); end
`endif
    @(negedge refclk);
    rst_n = 1'b1;
    step(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL startup_rst_hold: got %b exp 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0 || sys_reset_n !== 1'b0) begin errors++; $display("FAIL startup_wait_entry: got rst=%b srn=%b exp 0 0", pll_rst, sys_reset_n); end
    step(10);
    checks++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL startup_early_release: got %b exp 0", sys_reset_n); end
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || pll_ready !== 1'b1 || pll_rst !== 1'b0) begin errors++; $display("FAIL startup_run: got srn=%b rdy=%b rst=%b exp 1 1 0", sys_reset_n, pll_ready, pll_rst); end
  endtask

  task automatic test_lock_loss;
    pll_locked = 1'b0;
    step(2);
    checks++; if (sys_reset_n !== 1'b1) begin errors++; $display("FAIL lockloss_sync_delay: got %b exp 1", sys_reset_n); end
    step(1);
    checks++; if (sys_reset_n !== 1'b0 || pll_ready !== 1'b0 || pll_rst !== 1'b1) begin errors++; $display("FAIL lockloss_drop: got srn=%b rdy=%b rst=%b exp 0 0 1", sys_reset_n, pll_ready, pll_rst); end
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    checks++; if (lockloss_cnt !== 8'd1) begin errors++; $display("FAIL lockloss_cnt: got %0d exp 1", lockloss_cnt); end
`endif
    step(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL lockloss_rst_hold: got %b exp 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL lockloss_rst_end: got %b exp 0", pll_rst); end
  endtask

  task automatic test_timeout_fault;
    step(99);
    checks++; if (pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL timeout_early: got rst=%b retry=%0d exp 0 0", pll_rst, retry_cnt); end
    step(1);
    checks++; if (retry_cnt !== 4'd1 || pll_rst !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL timeout_first: got retry=%0d rst=%b flt=%b exp 1 1 0", retry_cnt, pll_rst, fault); end
    step(103);
    checks++; if (fault !== 1'b0 || retry_cnt !== 4'd1) begin errors++; $display("FAIL timeout_second_early: got flt=%b retry=%0d exp 0 1", fault, retry_cnt); end
    step(1);
    checks++; if (fault !== 1'b1 || retry_cnt !== 4'd2 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0) begin errors++; $display("FAIL fault_entry: got flt=%b retry=%0d rst=%b srn=%b exp 1 2 1 0", fault, retry_cnt, pll_rst, sys_reset_n); end
    step(20);
    checks++; if (fault !== 1'b1 || retry_cnt !== 4'd2) begin errors++; $display("FAIL fault_hold: got flt=%b retry=%0d exp 1 2", fault, retry_cnt); end
    sw_relock = 1'b1;
    step(1);
    sw_relock = 1'b0;
    checks++; if (fault !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL relock_exit: got flt=%b retry=%0d rst=%b exp 0 0 1", fault, retry_cnt, pll_rst); end
    step(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL relock_rst_hold: got %b exp 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL relock_rst_end: got %b exp 0", pll_rst); end
  endtask

  task automatic test_glitch;
    pll_locked = 1'b1;
    step(8);
    pll_locked = 1'b0;
    step(3);
    checks++; if (sys_reset_n !== 1'b0 || pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL glitch_back: got srn=%b rst=%b retry=%0d exp 0 0 0", sys_reset_n, pll_rst, retry_cnt); end
    pll_locked = 1'b1;
    step(10);
    checks++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL glitch_early_run: got %b exp 0", sys_reset_n); end
    step(1);
    checks++; if (sys_reset_n !== 1'b1 || pll_ready !== 1'b1 || retry_cnt !== 4'd0) begin errors++; $display("FAIL glitch_run: got srn=%b rdy=%b retry=%0d exp 1 1 0", sys_reset_n, pll_ready, retry_cnt); end
  endtask

  task automatic test_relock_vs_timeout;
    pll_locked = 1'b0;
    step(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rvt_lockloss: got %b exp 1", pll_rst); end
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    checks++; if (lockloss_cnt !== 8'd2) begin errors++; $display("FAIL rvt_lockloss_cnt: got %0d exp 2", lockloss_cnt); end
`endif
    step(4);
    step(100);
    checks++; if (retry_cnt !== 4'd1 || pll_rst !== 1'b1) begin errors++; $display("FAIL rvt_first_timeout: got retry=%0d rst=%b exp 1 1", retry_cnt, pll_rst); end
    step(4);
    step(99);
    sw_relock = 1'b1;
    step(1);
    sw_relock = 1'b0;
    checks++; if (fault !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL rvt_priority: got flt=%b retry=%0d rst=%b exp 0 0 1", fault, retry_cnt, pll_rst); end
    step(3);
    checks++; if (pll_rst !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL rvt_rst_hold: got rst=%b flt=%b exp 1 0", pll_rst, fault); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL rvt_rst_end: got %b exp 0", pll_rst); end
  endtask

  task automatic test_async_reset;
    step(100);
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL ar_pre_retry: got %0d exp 1", retry_cnt); end
    step(4);
    pll_locked = 1'b1;
    step(5);
    checks++; if (pll_rst !== 1'b0 || sys_reset_n !== 1'b0) begin errors++; $display("FAIL ar_in_stable: got rst=%b srn=%b exp 0 0", pll_rst, sys_reset_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || pll_ready !== 1'b0 || fault !== 1'b0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL ar_async: got rst=%b srn=%b rdy=%b flt=%b retry=%0d exp 1 0 0 0 0", pll_rst, sys_reset_n, pll_ready, fault, retry_cnt); end
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    checks++; if (lockloss_cnt !== 8'd0) begin errors++; $display("FAIL ar_lockloss: got %0d exp 0", lockloss_cnt); end
`endif
    @(negedge refclk);
    rst_n = 1'b1;
    step(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL ar_restart_hold: got %b exp 1", pll_rst); end
    step(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL ar_restart_end: got %b exp 0", pll_rst); end
    step(11);
    checks++; if (sys_reset_n !== 1'b1 || pll_ready !== 1'b1) begin errors++; $display("FAIL ar_run: got srn=%b rdy=%b exp 1 1", sys_reset_n, pll_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lock_loss();
    test_timeout_fault();
    test_glitch();
    test_relock_vs_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
